// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions.
// Holds the frame-state enum, the prefix scan codes, the event word layout
// and a parity helper. Every PS/2 RX file imports this package.
package ps2_pkg;

    // Frame receiver states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Prefix bytes. Each one modifies the next event and is not queued.
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Queued event word: {ext, break, code[7:0]}.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    localparam int unsigned EVT_W = $bits(evt_t);

    // The 8 data bits plus the parity bit must have odd parity.
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO for the PS/2 receiver.
// Ports:
//   clk, reset         - system clock, asynchronous active-low reset
//   push, push_data    - write request and write word
//   pop                - read request; ignored while the FIFO is empty
//   head               - word at the read pointer
//   full, empty        - occupancy flags
// A push while full succeeds only when a pop happens in the same cycle.
// DEPTH must be a power of two so that the pointers wrap naturally.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO can proceed alongside it.
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);

    // Storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver with scan-code decoding and an event FIFO.
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   keyb_clk, keyb_data   - raw PS/2 lines, asynchronous to clk
//   evt_ready             - consumer ready
//   evt_valid             - FIFO head holds an event
//   evt_code/break/ext    - head event fields
//   frame_err             - one-cycle pulse for each rejected or timed-out frame
//   overflow              - one-cycle pulse when an event is dropped on a full FIFO
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizers and keyboard-clock history.
    logic       kc_meta;
    logic       kc_sync;
    logic       kd_meta;
    logic       kd_sync;
    logic [3:0] hist;
    logic       kclk_fall_c;

    // Frame receiver.
    frame_state_t     state;
    frame_state_t     state_d;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_d;
    logic [7:0]       shreg;
    logic [7:0]       shreg_d;
    logic             par_bit;
    logic             par_bit_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             byte_ok;
    logic             byte_ok_d;
    logic [7:0]       byte_q;
    logic [7:0]       byte_q_d;
    logic             frame_err_d;

    // Decoder and FIFO interface.
    logic pend_ext;
    logic pend_ext_d;
    logic pend_brk;
    logic pend_brk_d;
    logic push_c;
    logic pop_c;
    evt_t push_evt_c;
    evt_t head_evt;
    logic fifo_full;
    logic fifo_empty;

    // Both lines and the history reset to idle-high, so releasing reset cannot look like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kc_meta <= 1'b1;
            kc_sync <= 1'b1;
            kd_meta <= 1'b1;
            kd_sync <= 1'b1;
            hist    <= 4'b1111;
        end else begin
            kc_meta <= keyb_clk;
            kc_sync <= kc_meta;
            kd_meta <= keyb_data;
            kd_sync <= kd_meta;
            hist    <= {hist[2:0], kc_sync};
        end
    end

    // Accept a falling edge only after two high samples followed by two low samples, which filters glitches.
    assign kclk_fall_c = (hist == 4'b1100);

    // Frame receiver: next-state logic.
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        par_bit_d   = par_bit;
        tmo_cnt_d   = tmo_cnt;
        byte_ok_d   = 1'b0;
        byte_q_d    = byte_q;
        frame_err_d = 1'b0;

        if (kclk_fall_c) begin
            tmo_cnt_d = '0;
            case (state)
                IDLE: begin
                    if (!kd_sync) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d   = {kd_sync, shreg[7:1]};
                    bit_cnt_d = bit_cnt + 3'(1);
                    if (bit_cnt == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_bit_d = kd_sync;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (kd_sync && frame_parity_ok(shreg, par_bit)) begin
                        byte_ok_d = 1'b1;
                        byte_q_d  = shreg;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state != IDLE) begin
            // A stalled frame is abandoned after TIMEOUT_CYCLES quiet cycles.
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                tmo_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Frame receiver: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo_cnt   <= '0;
            byte_ok   <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            par_bit   <= par_bit_d;
            tmo_cnt   <= tmo_cnt_d;
            byte_ok   <= byte_ok_d;
            byte_q    <= byte_q_d;
            frame_err <= frame_err_d;
        end
    end

    // Decoder: prefixes set pending flags, any other byte becomes an event.
    // A frame error also clears the flags, so a corrupted sequence cannot leak a prefix into the next key.
    always_comb begin
        pend_ext_d      = pend_ext;
        pend_brk_d      = pend_brk;
        push_c          = 1'b0;
        push_evt_c.ext  = pend_ext;
        push_evt_c.brk  = pend_brk;
        push_evt_c.code = byte_q;

        if (frame_err) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
        end else if (byte_ok) begin
            if (byte_q == SC_EXT) begin
                pend_ext_d = 1'b1;
            end else if (byte_q == SC_BREAK) begin
                pend_brk_d = 1'b1;
            end else begin
                push_c     = 1'b1;
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
            end
        end
    end

    assign pop_c = evt_valid & evt_ready;

    // Pending prefix flags and the overflow pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pend_ext <= pend_ext_d;
            pend_brk <= pend_brk_d;
            overflow <= push_c & fifo_full & ~pop_c;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_evt_c),
        .pop       (pop_c),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: a queue-based decoder model, a per-cycle compare process and directed frames.
module tb_ps2_rx_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 2000;
    localparam int          H     = 8;    // PS/2 half-period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       keyb_clk = 1'b1;
    logic       keyb_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       frame_err;
    logic       overflow;

    ps2_rx_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keyb_clk  (keyb_clk),
        .keyb_data (keyb_data),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_break (evt_break),
        .evt_ext   (evt_ext),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model state: expected queue of {ext, break, code}, prefix flags, expected pulse counts.
    logic [9:0] exp_q[$];
    logic [9:0] pop_log[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         exp_err = 0;
    int         exp_ovf = 0;
    int         dut_err = 0;
    int         dut_ovf = 0;
    int         wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (exp_q.size() == DEPTH) exp_ovf++;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_err();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    // Compare process: head event against the model on every cycle it is valid.
    always @(negedge clk) begin
        if (!reset) begin
            wait_cnt = 0;
        end else begin
            if (frame_err) dut_err++;
            if (overflow) dut_ovf++;
            if (evt_valid) begin
                wait_cnt = 0;
                check("valid_vs_model", 32'(evt_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0)
                    check("head_event", 32'({evt_ext, evt_break, evt_code}), 32'(exp_q[0]));
                if (evt_ready) begin
                    pop_log.push_back({evt_ext, evt_break, evt_code});
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                wait_cnt++;
                if (wait_cnt > 12) begin
                    check("event_latency", 32'(evt_valid), 32'd1);
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        keyb_data = b;
        tick(H);
        keyb_clk = 1'b0;
        tick(H);
        keyb_clk = 1'b1;
    endtask

    // Full 11-bit frame; the model is updated at the stop-bit falling edge.
    task automatic send_frame(input logic [7:0] b, input logic flip, input logic chk_lat);
        logic p;
        p = ~(^b) ^ flip;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        keyb_data = 1'b1;
        tick(H);
        keyb_clk = 1'b0;
        if (flip) model_err();
        else model_byte(b);
        if (chk_lat) begin
            repeat (5) @(posedge clk);
            @(negedge clk) check("valid_before_push", 32'(evt_valid), 32'd0);
            @(posedge clk);
            @(negedge clk) check("valid_after_push", 32'(evt_valid), 32'd1);
            @(posedge clk);
            #1;
        end else begin
            tick(H);
        end
        keyb_clk = 1'b1;
        tick(H);
    endtask

    task automatic check_pop(input string name, input logic [9:0] want);
        logic [9:0] got;
        got = 10'h3FF;
        if (pop_log.size() != 0) got = pop_log.pop_front();
        check(name, 32'(got), 32'(want));
    endtask

    initial begin
        int base;
        tick(3);
        @(negedge clk) check("reset_outputs",
            32'({evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        evt_ready = 1'b1;
        tick(5);

        // Plain make code with push latency.
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(4);
        check_pop("evt_1c", 10'h01C);

        // Break and extended-break prefixes.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        tick(4);
        check_pop("evt_f0_1c", 10'h11C);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        tick(4);
        check_pop("evt_e0_f0_74", 10'h374);
        check("e0_f0_74_single", 32'(pop_log.size()), 32'd0);

        // Parity error drops the frame and clears a pending break.
        send_frame(8'hF0, 1'b0, 1'b0);
        base = dut_err;
        send_frame(8'h1C, 1'b1, 1'b0);
        check("parity_err_pulse", 32'(dut_err - base), 32'd1);
        check("parity_no_event", 32'(pop_log.size()), 32'd0);
        send_frame(8'h16, 1'b0, 1'b0);
        tick(4);
        check_pop("evt_16_after_err", 10'h016);

        // Timeout after start bit plus four data bits, with an extended prefix pending.
        send_frame(8'hE0, 1'b0, 1'b0);
        base = dut_err;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        keyb_data = 1'b1;
        tick(1900);
        check("timeout_not_early", 32'(dut_err - base), 32'd0);
        tick(200);
        check("timeout_err_pulse", 32'(dut_err - base), 32'd1);
        model_err();
        send_frame(8'h29, 1'b0, 1'b0);
        tick(4);
        check_pop("evt_29_after_tmo", 10'h029);

        // Overflow on the fifth event while the consumer stalls.
        evt_ready = 1'b0;
        base = dut_ovf;
        send_frame(8'h15, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        check("no_ovf_at_four", 32'(dut_ovf - base), 32'd0);
        send_frame(8'h2C, 1'b0, 1'b0);
        check("ovf_on_fifth", 32'(dut_ovf - base), 32'd1);
        @(negedge clk) check("stalled_head", 32'({evt_valid, evt_ext, evt_break, evt_code}), 32'h415);
        @(posedge clk);
        #1;
        evt_ready = 1'b1;
        tick(10);
        check_pop("drain_0", 10'h015);
        check_pop("drain_1", 10'h01D);
        check_pop("drain_2", 10'h024);
        check_pop("drain_3", 10'h02D);
        check("drain_done", 32'(pop_log.size()), 32'd0);

        // Reset in the middle of a frame with an event still queued.
        evt_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(1'b1);
        reset = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(2);
        @(negedge clk) check("midframe_reset_outputs",
            32'({evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        base = dut_err;
        tick(30);
        @(negedge clk) check("post_reset_empty", 32'(evt_valid), 32'd0);
        check("post_reset_no_err", 32'(dut_err - base), 32'd0);
        @(posedge clk);
        #1;
        evt_ready = 1'b1;
        send_frame(8'h45, 1'b0, 1'b0);
        tick(4);
        check_pop("evt_45_after_reset", 10'h045);

        tick(20);
        check("frame_err_count", 32'(dut_err), 32'(exp_err));
        check("overflow_count", 32'(dut_ovf), 32'(exp_ovf));
        check("model_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the event FIFO depth (power of two, at least 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000, SHALL set the number of clk cycles without an accepted keyboard-clock edge that aborts a frame.
REQ-003 Port clk, input, 1 bit, SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous active-low reset (low = reset asserted).
REQ-005 Port keyb_clk, input, 1 bit, SHALL be the raw PS/2 clock line, asynchronous to clk.
REQ-006 Port keyb_data, input, 1 bit, SHALL be the raw PS/2 data line, asynchronous to clk.
REQ-007 Port evt_ready, input, 1 bit, SHALL be the consumer's ready signal for the event handshake.
REQ-008 Port evt_valid, output, 1 bit, SHALL be high while the FIFO head holds an event.
REQ-009 Port evt_code, output, 8 bits, SHALL be the head event's scan code.
REQ-010 Port evt_break, output, 1 bit, SHALL be high if the head event is a key release (F0-prefixed).
REQ-011 Port evt_ext, output, 1 bit, SHALL be high if the head event is extended (E0-prefixed).
REQ-012 Port frame_err, output, 1 bit, SHALL pulse for one cycle on any rejected frame.
REQ-013 Port overflow, output, 1 bit, SHALL pulse for one cycle when an event is dropped because the FIFO is full.

Function
REQ-014 keyb_clk and keyb_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 A 4-bit history hist SHALL shift the synchronized keyb_clk into hist[0] every cycle; an accepted edge SHALL occur only when hist == 4'b1100.
REQ-016 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP, with the following transitions, all taken on accepted edges.
REQ-017 In IDLE, an edge with data 0 SHALL move the FSM to DATA with bit count 0; an edge with data 1 SHALL be ignored.
REQ-018 DATA SHALL capture 8 bits LSB first and move to PARITY after the 8th bit.
REQ-019 PARITY SHALL capture the parity bit and move to STOP.
REQ-020 On the STOP edge, if data is 1 and the 9 bits (8 data + parity) have odd parity, the FSM SHALL emit byte_ok for one cycle; otherwise it SHALL pulse frame_err. In both cases it SHALL return to IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYCLES consecutive cycles with no accepted edge SHALL pulse frame_err and return the FSM to IDLE, discarding the partial byte.
REQ-022 The decoder SHALL process each accepted byte as follows.
  - Byte 0xE0 sets pend_ext and pushes no event.
  - Byte 0xF0 sets pend_break and pushes no event.
  - Any other byte pushes {pend_ext, pend_break, byte} and clears both flags.
REQ-023 frame_err SHALL clear pend_ext and pend_break.
REQ-024 Sequence E0 F0 74 SHALL yield exactly one event: code 0x74, ext=1, break=1.
REQ-025 Push SHALL occur on the clock edge ending the byte_ok cycle; with the FIFO previously empty, evt_valid SHALL be high on the next cycle.
REQ-026 A pop SHALL occur when evt_valid and evt_ready are both high at a rising clk edge.
  - evt_code, evt_break and evt_ext remain stable while evt_valid is high and evt_ready is low.
REQ-027 A push when the FIFO is full and no pop occurs SHALL drop the new event and pulse overflow; the FIFO contents are unchanged.
REQ-028 A simultaneous push and pop when full SHALL perform both, with no overflow.
REQ-029 A simultaneous push and pop when empty SHALL perform a push only; the pop is ignored because evt_valid was low.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter distinguishing full from empty.

Reset
REQ-031 While reset is low, the block SHALL force the following values.
  - FSM in IDLE, bit count 0, timeout counter 0.
  - Synchronizers and hist all 1s.
  - pend_ext = pend_break = 0.
  - FIFO empty.
  - Outputs: evt_valid=0, evt_code=0x00, evt_break=0, evt_ext=0, frame_err=0, overflow=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and all queued events.
  - The first frame after release is decoded normally.
  - No spurious edge is detected at release.

Structure
REQ-033 A shared package ps2_pkg SHALL hold the following items.
  - The frame-state enum.
  - Constants SC_EXT=8'hE0 and SC_BREAK=8'hF0.
  - The 10-bit event word layout {ext, break, code[7:0]}.
REQ-034 The FIFO SHALL be a separate sub-module, ps2_evt_fifo, parameterized by depth and width.
  - It provides push/pop/full/empty ports.
  - It resets asynchronously, active-low.

Verification
REQ-035 Byte 0x1C with correct odd parity and stop 1 -> one event: code 0x1C, break=0, ext=0; evt_valid high 1 cycle after byte_ok.
REQ-036 Bytes F0 1C -> one event: code 0x1C, break=1; E0 F0 74 -> one event: code 0x74, ext=1, break=1.
REQ-037 Byte 0x1C with a flipped parity bit -> frame_err pulse, no event; a following valid 0x16 -> event 0x16 with break=0.
REQ-038 Start bit plus 4 data bits, then keyb_clk held high for 2000 cycles -> frame_err pulse, FSM in IDLE; the next full frame is decoded correctly.
REQ-039 With evt_ready=0, send 5 bytes 0x15,0x1D,0x24,0x2D,0x2C -> one overflow pulse on the 5th; then evt_ready=1 pops 0x15,0x1D,0x24,0x2D in order.
REQ-040 Drive reset low after the 6th data bit of a frame, then release -> all outputs at reset values, FIFO empty; the next 0x45 frame -> event 0x45.
